// File: rtl/accum_alu.sv
// Accumulator ALU: a 2*WIDTH-bit accumulator updated by valid/ready commands,
// with single-cycle logic/arithmetic ops and bit-serial (one bit per cycle) MUL and DIV.
module accum_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [3:0]         opcode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] C,
  output logic               carry,
  output logic               error,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [2*WIDTH-1:0]   work_reg, work_next;
  logic [WIDTH-1:0]     opnd_reg, opnd_next;
  logic [CW-1:0]        count_reg, count_next;
  logic                 carry_reg, carry_next;
  logic                 error_reg, error_next;
  logic                 done_reg, done_next;

  logic [WIDTH-1:0]     l;
  logic [WIDTH:0]       add_sum, sub_diff, mul_sum, div_upper, div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step;
  logic                 last_iter;

  assign l         = acc_reg[WIDTH-1:0];
  assign add_sum   = {1'b0, l} + {1'b0, A};
  assign sub_diff  = {1'b0, l} - {1'b0, A};
  assign last_iter = (count_reg == CW'(WIDTH - 1));

  // Shift-add multiply: work holds {partial product, unconsumed multiplier bits}.
  assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, (work_reg[0] ? opnd_reg : ZERO)};
  assign mul_step = {mul_sum, work_reg[WIDTH-1:1]};

  // Restoring divide: work holds {remainder, dividend bits shifting into quotient}.
  assign div_upper = work_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_upper - {1'b0, opnd_reg};
  assign div_step  = div_diff[WIDTH]
                   ? {div_upper[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  work_reg[WIDTH-2:0], 1'b1};

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    work_next  = work_reg;
    opnd_next  = opnd_reg;
    count_next = count_reg;
    carry_next = carry_reg;
    error_next = error_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          case (opcode)
            4'd0: ;
            4'd1: begin
              acc_next   = '0;
              carry_next = 1'b0;
              error_next = 1'b0;
            end
            4'd2: begin
              acc_next   = {ZERO, l[WIDTH-2:0], 1'b0};
              carry_next = l[WIDTH-1];
            end
            4'd3: begin
              acc_next   = {ZERO, 1'b0, l[WIDTH-1:1]};
              carry_next = l[0];
            end
            4'd4: begin
              acc_next   = {ZERO, sub_diff[WIDTH-1:0]};
              carry_next = sub_diff[WIDTH];
              error_next = error_reg | sub_diff[WIDTH];
            end
            4'd5: begin
              acc_next   = {ZERO, add_sum[WIDTH-1:0]};
              carry_next = add_sum[WIDTH];
              error_next = error_reg | add_sum[WIDTH];
            end
            4'd6: begin
              opnd_next  = A;
              work_next  = {ZERO, l};
              count_next = '0;
              state_next = MUL;
            end
            4'd7: begin
              if (A == ZERO) begin
                error_next = 1'b1;
              end else begin
                opnd_next  = A;
                work_next  = {ZERO, l};
                count_next = '0;
                state_next = DIV;
              end
            end
            4'd8:  acc_next = {ZERO, l | A};
            4'd9:  acc_next = {ZERO, l & A};
            4'd10: acc_next = {ZERO, l ^ A};
            4'd11: acc_next = {ZERO, ~l};
            4'd12: acc_next = {ZERO, ~(l & A)};
            4'd13: acc_next = {ZERO, ~(l | A)};
            4'd14: acc_next = {ZERO, ~(l ^ A)};
            default: acc_next = {ZERO, A};
          endcase
        end
      end
      MUL, DIV: begin
        work_next  = (state_reg == MUL) ? mul_step : div_step;
        count_next = count_reg + CW'(1);
        if (last_iter) begin
          acc_next   = work_next;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      work_reg  <= '0;
      opnd_reg  <= '0;
      count_reg <= '0;
      carry_reg <= 1'b0;
      error_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      work_reg  <= work_next;
      opnd_reg  <= opnd_next;
      count_reg <= count_next;
      carry_reg <= carry_next;
      error_reg <= error_next;
      done_reg  <= done_next;
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign C        = acc_reg;
  assign carry    = carry_reg;
  assign error    = error_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_accum_alu.sv
// Testbench for accum_alu (WIDTH=16): directed scenarios with literal expectations,
// then randomized commands checked every cycle against an arithmetic reference model.
module tb_accum_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A;
  logic [3:0]    opcode;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] C;
  logic          carry, error, done;

  int tests = 0;
  int fails = 0;

  accum_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .opcode(opcode), .in_valid(in_valid),
    .in_ready(in_ready), .C(C), .carry(carry), .error(error), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state is just the architectural values plus a busy countdown.
  logic [31:0] m_acc, m_pend;
  logic        m_carry, m_err, m_done, m_valid = 1'b0;
  int          m_left;

  function automatic logic [33:0] single_op(input logic [3:0] op, input logic [31:0] acc,
                                            input logic [15:0] a, input logic c_in, input logic e_in);
    longint l = longint'(acc[15:0]);
    longint av = longint'(a);
    longint t;
    logic [31:0] r = acc;
    logic [15:0] lb = acc[15:0];
    logic c = c_in;
    logic e = e_in;
    case (op)
      4'd1: begin r = 0; c = 0; e = 0; end
      4'd2: begin t = l * 2; r = 32'(t % 65536); c = (t >= 65536); end
      4'd3: begin r = 32'(l / 2); c = (l % 2) == 1; end
      4'd4: begin c = (l < av); r = 32'((l + 65536 - av) % 65536); e = e | c; end
      4'd5: begin t = l + av; r = 32'(t % 65536); c = (t >= 65536); e = e | c; end
      4'd8:  r = {16'h0, lb | a};
      4'd9:  r = {16'h0, lb & a};
      4'd10: r = {16'h0, lb ^ a};
      4'd11: r = 32'(65535 - l);
      4'd12: r = {16'h0, ~(lb & a)};
      4'd13: r = {16'h0, ~(lb | a)};
      4'd14: r = {16'h0, ~(lb ^ a)};
      4'd15: r = {16'h0, a};
      default: ;
    endcase
    return {e, c, r};
  endfunction

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_valid <= 1'b1;
      m_acc   <= '0;
      m_carry <= 1'b0;
      m_err   <= 1'b0;
      m_left  <= 0;
    end else if (m_valid && m_left > 0) begin
      if (m_left == 1) begin
        m_acc  <= m_pend;
        m_done <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (m_valid && in_valid) begin
      if (opcode == 4'd6) begin
        m_pend <= 32'(longint'(m_acc[15:0]) * longint'(A));
        m_left <= W;
      end else if (opcode == 4'd7) begin
        if (A == 16'h0) m_err <= 1'b1;
        else begin
          m_pend <= {m_acc[15:0] % A, m_acc[15:0] / A};
          m_left <= W;
        end
      end else begin
        {m_err, m_carry, m_acc} <= single_op(opcode, m_acc, A, m_carry, m_err);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("C", C, m_acc);
      chk("carry", 32'(carry), 32'(m_carry));
      chk("error", 32'(error), 32'(m_err));
      chk("done", 32'(done), 32'(m_done));
      chk("in_ready", 32'(in_ready), 32'(m_left == 0));
    end
  end

  // Called at a negedge; holds the command until accepted, returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [15:0] a);
    int n = 0;
    opcode = op; A = a; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", 32'(n), 32'(0));
    @(posedge clk);
    @(negedge clk);
    $display("[TB] cmd op=%0d A=0x%h -> C=0x%h carry=%0b error=%0b", op, a, C, carry, error);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [3:0] op;
    logic [15:0] a;
    int r;
    rst = 1'b1; in_valid = 1'b0; A = '0; opcode = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1. reset then NOOP
    issue(4'd0, 16'h0);
    chk("t1_C", C, 32'h0);
    chk("t1_ready", 32'(in_ready), 32'd1);

    // 2. ADD chain and overflow
    issue(4'd15, 16'h0001);
    issue(4'd5, 16'h0001); chk("t2_add2", C, 32'd2);
    issue(4'd5, 16'h0001); chk("t2_add3", C, 32'd3);
    issue(4'd5, 16'h0001); chk("t2_add4", C, 32'd4);
    issue(4'd15, 16'hFFFF);
    issue(4'd5, 16'h0001);
    chk("t2_ovf_C", C, 32'h0);
    chk("t2_ovf_carry", 32'(carry), 32'd1);
    chk("t2_ovf_err", 32'(error), 32'd1);
    issue(4'd0, 16'h0); chk("t2_sticky", 32'(error), 32'd1);
    issue(4'd1, 16'h0);
    chk("t2_rst_err", 32'(error), 32'd0);
    chk("t2_rst_carry", 32'(carry), 32'd0);

    // 3. logic ops
    issue(4'd15, 16'h00F0);
    issue(4'd9, 16'h00B3);  chk("t3_and", C, 32'h00B0);
    issue(4'd10, 16'hFFFF); chk("t3_xor", C, 32'hFF4F);
    issue(4'd11, 16'h0);    chk("t3_not", C, 32'h00B0);
    issue(4'd2, 16'h0);     chk("t3_shl", C, 32'h0160);
    chk("t3_shl_carry", 32'(carry), 32'd0);

    // 4. MUL with a command held while busy
    issue(4'd15, 16'hFFFF);
    issue(4'd6, 16'hFFFF);
    opcode = 4'd5; A = 16'h0001;
    chk("t4_busy", 32'(in_ready), 32'd0);
    wait_done(n);
    chk("t4_latency", 32'(n), 32'd16);
    chk("t4_C", C, 32'hFFFE0001);
    issue(4'd5, 16'h0001);
    chk("t4_held_add", C, 32'h2);

    // 5. DIV and DIV by zero
    issue(4'd15, 16'd100);
    issue(4'd7, 16'd7);
    in_valid = 1'b0;
    wait_done(n);
    chk("t5_div", C, 32'h0002000E);
    @(negedge clk);
    issue(4'd7, 16'd0);
    chk("t5_div0_C", C, 32'h0002000E);
    chk("t5_div0_err", 32'(error), 32'd1);
    chk("t5_div0_ready", 32'(in_ready), 32'd1);
    chk("t5_div0_done", 32'(done), 32'd0);

    // 6. reset mid-MUL
    issue(4'd6, 16'h1234);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_C", C, 32'h0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    issue(4'd5, 16'd5);
    chk("t6_add", C, 32'd5);

    // Randomized phase, checked by the per-cycle compare process.
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if (r < 15) begin
        in_valid = 1'b0;
        @(negedge clk);
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd1 && ($urandom % 4) != 0) op = 4'd5;
        case ($urandom_range(0, 5))
          0: a = 16'h0;
          1: a = 16'hFFFF;
          default: a = 16'($urandom);
        endcase
        issue(op, a);
      end
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
